// File: rtl/pico_mips_mc.sv
// pico_mips_mc: accumulator-based multi-cycle micro-processor.
// Instruction word = {op[3:0], r[3:0], imm[N-1:0]} fetched from an external
// synchronous ROM; signed fractional multiply is done by a sequential
// shift-add unit taking exactly N cycles.
module pico_mips_mc #(
  parameter int N     = 8,
  parameter int NREG  = 4,
  parameter int PSIZE = 5
) (
  input  logic             clk,
  input  logic             nReset,
  output logic [PSIZE-1:0] iaddr,
  input  logic [N+7:0]     instr,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  output logic [N-1:0]     acc,
  output logic             halted
);

  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(N);

  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_LDR  = 4'd2;
  localparam logic [3:0] OP_STR  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_ADDR = 4'd5;
  localparam logic [3:0] OP_SUBR = 4'd6;
  localparam logic [3:0] OP_MULI = 4'd7;
  localparam logic [3:0] OP_MULR = 4'd8;
  localparam logic [3:0] OP_INW  = 4'd9;
  localparam logic [3:0] OP_OUT  = 4'd10;
  localparam logic [3:0] OP_JMP  = 4'd11;
  localparam logic [3:0] OP_BNZ  = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXEC    = 3'd1,
    S_MUL     = 3'd2,
    S_WAIT_IN = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t           state_r;
  logic [PSIZE-1:0] pc_r;
  logic [N-1:0]     regs_r [NREG];
  logic [2*N-1:0]   mcand_r;
  logic [N-1:0]     mplier_r;
  logic [2*N-1:0]   prod_r;
  logic [CW-1:0]    cnt_r;

  logic [3:0]       op_s;
  logic [RW-1:0]    r_s;
  logic [N-1:0]     imm_s;
  logic [N-1:0]     rval_s;
  logic [PSIZE-1:0] pc_inc_s;
  logic             mul_last_s;
  logic [2*N-1:0]   addend_s;
  logic [2*N-1:0]   prod_next_s;
  logic             unused_instr_s;

  assign op_s       = instr[N+7:N+4];
  assign r_s        = instr[N+RW-1:N];
  assign imm_s      = instr[N-1:0];
  assign rval_s     = regs_r[r_s];
  assign pc_inc_s   = pc_r + PSIZE'(1);
  assign mul_last_s = (cnt_r == CW'(N - 1));
  assign iaddr      = pc_r;
  // Register-select bits above log2(NREG) are ignored by design.
  assign unused_instr_s = ^instr;

  // One shift-add step: bits below the sign add the shifted multiplicand,
  // the sign bit carries negative weight so the last step subtracts it.
  always_comb begin
    addend_s    = {(2*N){1'b0}};
    prod_next_s = prod_r;
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {(2*N){1'b0}};
    end
    if (mul_last_s) begin
      prod_next_s = prod_r - addend_s;
    end else begin
      prod_next_s = prod_r + addend_s;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r   <= S_FETCH;
      pc_r      <= {PSIZE{1'b0}};
      acc       <= {N{1'b0}};
      out_data  <= {N{1'b0}};
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      halted    <= 1'b0;
      mcand_r   <= {(2*N){1'b0}};
      mplier_r  <= {N{1'b0}};
      prod_r    <= {(2*N){1'b0}};
      cnt_r     <= {CW{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {N{1'b0}};
      end
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        S_FETCH: begin
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          // Simple instructions return to FETCH with pc+1; the multi-cycle,
          // control-flow and halt cases below override state and pc.
          state_r <= S_FETCH;
          pc_r    <= pc_inc_s;
          case (op_s)
            OP_LDI:  acc <= imm_s;
            OP_LDR:  acc <= rval_s;
            OP_STR:  regs_r[r_s] <= acc;
            OP_ADDI: acc <= acc + imm_s;
            OP_ADDR: acc <= acc + rval_s;
            OP_SUBR: acc <= acc - rval_s;
            OP_MULI, OP_MULR: begin
              state_r  <= S_MUL;
              pc_r     <= pc_r;
              mcand_r  <= {{N{acc[N-1]}}, acc};
              mplier_r <= (op_s == OP_MULI) ? imm_s : rval_s;
              prod_r   <= {(2*N){1'b0}};
              cnt_r    <= {CW{1'b0}};
            end
            OP_INW: begin
              state_r  <= S_WAIT_IN;
              pc_r     <= pc_r;
              in_ready <= 1'b1;
            end
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_JMP: pc_r <= imm_s[PSIZE-1:0];
            OP_BNZ: begin
              if (acc != {N{1'b0}}) begin
                pc_r <= imm_s[PSIZE-1:0];
              end else begin
                pc_r <= pc_inc_s;
              end
            end
            OP_HALT: begin
              state_r <= S_HALT;
              pc_r    <= pc_r;
              halted  <= 1'b1;
            end
            default: begin
              // NOP and reserved opcodes only advance pc.
              pc_r <= pc_inc_s;
            end
          endcase
        end
        S_MUL: begin
          prod_r   <= prod_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (mul_last_s) begin
            // Q1.(N-1) result: drop the redundant sign bit and low fraction.
            acc     <= prod_next_s[2*N-2:N-1];
            pc_r    <= pc_inc_s;
            state_r <= S_FETCH;
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            acc      <= in_data;
            in_ready <= 1'b0;
            pc_r     <= pc_inc_s;
            state_r  <= S_FETCH;
          end
        end
        S_HALT: begin
          state_r <= S_HALT;
        end
        default: begin
          state_r <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pico_mips_mc.sv
// Bench for pico_mips_mc: instruction-level reference model compared every
// cycle, directed programs with literal expectations, then random programs.
module tb_pico_mips_mc;

  localparam int N     = 8;
  localparam int NREG  = 4;
  localparam int PSIZE = 5;

  logic             clk = 1'b0;
  logic             nReset = 1'b1;
  logic [PSIZE-1:0] iaddr;
  logic [N+7:0]     instr;
  logic [N-1:0]     in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic [N-1:0]     acc;
  logic             halted;

  logic [N+7:0] rom [32];

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int at1    = 0;

  pico_mips_mc #(.N(N), .NREG(NREG), .PSIZE(PSIZE)) dut (
    .clk(clk), .nReset(nReset), .iaddr(iaddr), .instr(instr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .acc(acc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM with one cycle of read latency.
  always @(posedge clk) instr <= rom[iaddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int r, input int imm);
    return {4'(op), 4'(r), 8'(imm)};
  endfunction

  // Signed Q1.7 product, computed with plain integer multiplication.
  function automatic logic [N-1:0] qmul(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa, sb, p;
    logic [31:0] pw;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    pw = p;
    return pw[2*N-2:N-1];
  endfunction

  // ---------------- reference model ----------------
  // phase: 0 fetch, 1 execute, 2 multiplying, 3 waiting for input, 4 halted
  int               m_phase;
  int               m_cnt;
  logic [PSIZE-1:0] m_pc;
  logic [N-1:0]     m_acc, m_out, m_pend;
  logic             m_outv;
  logic [N-1:0]     m_regs [NREG];
  logic [15:0]      m_inst;
  logic [3:0]       m_op;
  int               m_r;
  logic [N-1:0]     m_imm;

  assign m_inst = rom[m_pc];
  assign m_op   = m_inst[15:12];
  assign m_r    = int'(m_inst[11:8]) % NREG;
  assign m_imm  = m_inst[7:0];

  // Instruction-level model advanced once per clock.
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_phase <= 0; m_cnt <= 0; m_pc <= '0; m_acc <= '0; m_out <= '0;
      m_pend <= '0; m_outv <= 1'b0;
      for (int i = 0; i < NREG; i++) m_regs[i] <= '0;
    end else begin
      m_outv <= 1'b0;
      case (m_phase)
        0: m_phase <= 1;
        1: begin
          m_phase <= 0;
          m_pc    <= m_pc + 5'd1;
          case (m_op)
            4'd1:  m_acc <= m_imm;
            4'd2:  m_acc <= m_regs[m_r];
            4'd3:  m_regs[m_r] <= m_acc;
            4'd4:  m_acc <= m_acc + m_imm;
            4'd5:  m_acc <= m_acc + m_regs[m_r];
            4'd6:  m_acc <= m_acc - m_regs[m_r];
            4'd7, 4'd8: begin
              m_pend  <= qmul(m_acc, (m_op == 4'd7) ? m_imm : m_regs[m_r]);
              m_cnt   <= N;
              m_phase <= 2;
              m_pc    <= m_pc;
            end
            4'd9:  begin m_phase <= 3; m_pc <= m_pc; end
            4'd10: begin m_out <= m_acc; m_outv <= 1'b1; end
            4'd11: m_pc <= m_imm[PSIZE-1:0];
            4'd12: m_pc <= (m_acc != 8'd0) ? m_imm[PSIZE-1:0] : m_pc + 5'd1;
            4'd15: begin m_phase <= 4; m_pc <= m_pc; end
            default: ;
          endcase
        end
        2: begin
          if (m_cnt == 1) begin
            m_acc <= m_pend; m_pc <= m_pc + 5'd1; m_phase <= 0;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        3: begin
          if (in_valid) begin
            m_acc <= in_data; m_pc <= m_pc + 5'd1; m_phase <= 0;
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("iaddr",     iaddr,     m_pc);
    check("acc",       acc,       m_acc);
    check("out_data",  out_data,  m_out);
    check("out_valid", out_valid, m_outv);
    check("in_ready",  in_ready,  32'(m_phase == 3));
    check("halted",    halted,    32'(m_phase == 4));
  end

  always @(negedge clk) begin
    if (out_valid) pulses++;
    if (iaddr == 5'd1) at1++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold_reset();
    @(negedge clk);
    #2 nReset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #2 nReset = 1'b1;
    pulses = 0;
    at1 = 0;
  endtask

  task automatic wait_halt(input int budget, input string name, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check(name, halted, 1);
  endtask

  task automatic wait_addr(input logic [PSIZE-1:0] a, input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (iaddr != a && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, iaddr, a);
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, in_ready, 1);
  endtask

  initial begin
    int cyc;
    #1 nReset = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;

    // Basic sequence: LDI 5; ADDI 3; OUT; HALT
    hold_reset();
    rom[0] = mk(1, 0, 5); rom[1] = mk(4, 0, 3); rom[2] = mk(10, 0, 0); rom[3] = mk(15, 0, 0);
    release_reset();
    wait_halt(40, "t1_halt", cyc);
    check("t1_cycles", cyc, 8);
    repeat (3) @(negedge clk);
    check("t1_out", out_data, 8'h08);
    check("t1_pc_frozen", iaddr, 5'd3);
    check("t1_pulses", pulses, 1);
    check("t1_acc", acc, 8'h08);

    // Fractional multiply: 0.5*0.5 and the -1*-1 wrap
    hold_reset();
    rom[0] = mk(1, 0, 8'h40); rom[1] = mk(7, 0, 8'h40); rom[2] = mk(10, 0, 0);
    rom[3] = mk(1, 0, 8'h80); rom[4] = mk(7, 0, 8'h80); rom[5] = mk(15, 0, 0);
    release_reset();
    wait_halt(80, "t2_halt", cyc);
    check("t2_cycles", cyc, 28);
    check("t2_half_sq", out_data, 8'h20);
    check("t2_wrap", acc, 8'h80);

    // Input handshake with a long stall
    hold_reset();
    rom[0] = mk(9, 0, 0); rom[1] = mk(10, 0, 0); rom[2] = mk(15, 0, 0);
    release_reset();
    wait_ready(10, "t3_reach_wait");
    for (int i = 0; i < 10; i++) begin
      check("t3_ready_held", in_ready, 1);
      @(negedge clk);
    end
    #1 in_data = 8'h7F; in_valid = 1'b1;
    @(negedge clk);
    #1 in_data = 8'h11;
    wait_halt(20, "t3_halt", cyc);
    check("t3_acc", acc, 8'h7F);
    check("t3_out", out_data, 8'h7F);
    check("t3_pulses", pulses, 1);
    check("t3_ready_low", in_ready, 0);
    in_valid = 1'b0;

    // Countdown loop
    hold_reset();
    rom[0] = mk(1, 0, 3); rom[1] = mk(4, 0, 8'hFF); rom[2] = mk(12, 0, 1); rom[3] = mk(15, 0, 0);
    release_reset();
    wait_halt(60, "t4_halt", cyc);
    check("t4_cycles", cyc, 16);
    check("t4_acc", acc, 8'h00);
    check("t4_loop_cycles", at1, 6);

    // Overflow wrap, register round trip, pc wrap
    hold_reset();
    rom[0] = mk(1, 0, 8'h7F); rom[1] = mk(4, 0, 1); rom[2] = mk(3, 1, 0);
    rom[3] = mk(1, 0, 0); rom[4] = mk(5, 1, 0); rom[5] = mk(10, 0, 0);
    release_reset();
    wait_addr(5'd31, 100, "t5_reach_31");
    check("t5_acc", acc, 8'h80);
    check("t5_out", out_data, 8'h80);
    repeat (2) @(negedge clk);
    check("t5_pc_wrap", iaddr, 5'd0);

    // Reset during MUL cycle 3
    hold_reset();
    rom[0] = mk(1, 0, 8'h40); rom[1] = mk(7, 0, 8'h40); rom[2] = mk(15, 0, 0);
    release_reset();
    wait_addr(5'd1, 10, "t6_reach_mul");
    repeat (4) @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    check("t6_rst_acc", acc, 8'h00);
    check("t6_rst_pc", iaddr, 5'd0);
    check("t6_rst_outv", out_valid, 0);
    check("t6_rst_halted", halted, 0);
    release_reset();
    #1 check("t6_rel_pc", iaddr, 5'd0);
    check("t6_rel_acc", acc, 8'h00);
    wait_halt(40, "t6_halt", cyc);
    check("t6_rerun_acc", acc, 8'h20);

    // Reset during WAIT_IN
    hold_reset();
    rom[0] = mk(1, 0, 8'h12); rom[1] = mk(9, 0, 0); rom[2] = mk(15, 0, 0);
    release_reset();
    wait_ready(20, "t7_reach_wait");
    #2 in_data = 8'h55; nReset = 1'b0;
    #1;
    check("t7_rst_ready", in_ready, 0);
    check("t7_rst_acc", acc, 8'h00);
    release_reset();
    #1 check("t7_rel_pc", iaddr, 5'd0);
    in_data = 8'h66; in_valid = 1'b1;
    wait_halt(40, "t7_halt", cyc);
    check("t7_acc", acc, 8'h66);
    in_valid = 1'b0;

    // Random programs, random input traffic, occasional asynchronous reset
    for (int p = 0; p < 12; p++) begin
      hold_reset();
      for (int i = 0; i < 32; i++) begin
        int op;
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
        rom[i] = mk(op, $urandom_range(0, 15), $urandom_range(0, 255));
      end
      release_reset();
      repeat (300) begin
        @(negedge clk);
        #1 in_valid = ($urandom_range(0, 2) == 0);
        in_data = 8'($urandom);
        if ($urandom_range(0, 199) == 0) begin
          nReset = 1'b0;
          #2 nReset = 1'b1;
        end
      end
    end

    in_valid = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
